pe_add_pipe: RTL and testbench

- Parametrised, pipelined carry-lookahead add/subtract unit for the PE datapath.
- Successor to the fixed-width combinational adder family. It generalises width and segment size, adds a subtract mode, a signed-overflow flag, and valid/ready flow control.
- The operand is split into NSEG = W/SEG slices. One slice is resolved per pipeline stage with 4-bit lookahead groups inside it. The inter-slice carry is registered so timing closes at 64+ bits.

---
 rtl/pe_add_pipe_if.sv | 27 ++
 rtl/pe_add_pipe.sv | 152 +++++++++++++++
 tb/tb_pe_add_pipe.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/pe_add_pipe_if.sv
// Operand/result handshake bundle for the pipelined add/subtract unit.
// The master drives operands and out_ready; the slave is the adder itself.
interface pe_add_pipe_if #(
  parameter int W = 64
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         op;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  modport master (
    output in_valid, a, b, cin, op, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  modport slave (
    input  in_valid, a, b, cin, op, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );
endinterface

// File: rtl/pe_add_pipe.sv
// Pipelined carry-lookahead add/subtract: one SEG-bit slice resolved per stage,
// inter-slice carry registered, whole pipe freezes under output backpressure.
module pe_add_pipe #(
  parameter int W   = 64,
  parameter int SEG = 16
) (
  input logic         clk,
  input logic         rst,
  pe_add_pipe_if.slave bus
);
  localparam int NSEG = W / SEG;
  localparam int NGRP = SEG / 4;

  if (SEG <= 0 || (SEG % 4) != 0 || (W % SEG) != 0) begin : g_bad_cfg
    $error("pe_add_pipe: SEG must be a positive multiple of 4 that divides W");
  end
  if ($bits(bus.a) != W) begin : g_bad_bus
    $error("pe_add_pipe: interface width does not match W");
  end

  // One slice: 4-bit P/G groups, group carries by full lookahead from ci.
  function automatic logic [SEG:0] cla_slice(input logic [SEG-1:0] x,
                                             input logic [SEG-1:0] y,
                                             input logic           ci);
    logic [SEG-1:0]  p;
    logic [SEG-1:0]  g;
    logic [SEG-1:0]  s;
    logic [NGRP-1:0] gp;
    logic [NGRP-1:0] gg;
    logic [NGRP:0]   gc;
    logic            t;
    logic            u;
    p = x ^ y;
    g = x & y;
    for (int j = 0; j < NGRP; j++) begin
      gp[j] = &p[4*j +: 4];
      t = 1'b0;
      for (int q = 0; q < 4; q++) begin
        u = g[4*j+q];
        for (int m = q + 1; m < 4; m++) u = u & p[4*j+m];
        t = t | u;
      end
      gg[j] = t;
    end
    gc[0] = ci;
    for (int j = 1; j <= NGRP; j++) begin
      t = ci;
      for (int m = 0; m < j; m++) t = t & gp[m];
      for (int q = 0; q < j; q++) begin
        u = gg[q];
        for (int m = q + 1; m < j; m++) u = u & gp[m];
        t = t | u;
      end
      gc[j] = t;
    end
    for (int j = 0; j < NGRP; j++) begin
      for (int i = 0; i < 4; i++) begin
        t = gc[j];
        for (int m = 0; m < i; m++) t = t & p[4*j+m];
        for (int q = 0; q < i; q++) begin
          u = g[4*j+q];
          for (int m = q + 1; m < i; m++) u = u & p[4*j+m];
          t = t | u;
        end
        s[4*j+i] = p[4*j+i] ^ t;
      end
    end
    return {gc[NGRP], s};
  endfunction

  logic en_s;

  for (genvar k = 0; k < NSEG; k++) begin : g_stage
    // Operand bits still unresolved when entering this stage.
    localparam int RW = W - k * SEG;

    logic                   in_vld_s;
    logic                   in_c_s;
    logic [RW-1:0]          in_a_s;
    logic [RW-1:0]          in_b_s;
    logic [(k+1)*SEG-1:0]   nxt_s_s;
    logic [SEG:0]           res_s;
    logic                   vld_r;
    logic                   c_r;
    logic [(k+1)*SEG-1:0]   s_r;

    if (k == 0) begin : g_src
      assign in_vld_s = bus.in_valid;
      assign in_a_s   = bus.a;
      assign in_b_s   = bus.op ? ~bus.b : bus.b;
      assign in_c_s   = bus.op ? ~bus.cin : bus.cin;
      assign nxt_s_s  = res_s[SEG-1:0];
    end else begin : g_src
      assign in_vld_s = g_stage[k-1].vld_r;
      assign in_a_s   = g_stage[k-1].g_fwd.a_r;
      assign in_b_s   = g_stage[k-1].g_fwd.b_r;
      assign in_c_s   = g_stage[k-1].c_r;
      assign nxt_s_s  = {res_s[SEG-1:0], g_stage[k-1].s_r};
    end

    assign res_s = cla_slice(in_a_s[SEG-1:0], in_b_s[SEG-1:0], in_c_s);

    // Stage valid, slice carry and assembled sum; data only loads with a valid beat.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        vld_r <= 1'b0;
        c_r   <= 1'b0;
        s_r   <= {((k+1)*SEG){1'b0}};
      end else if (en_s) begin
        vld_r <= in_vld_s;
        if (in_vld_s) begin
          c_r <= res_s[SEG];
          s_r <= nxt_s_s;
        end
      end
    end

    if (k < NSEG - 1) begin : g_fwd
      logic [RW-SEG-1:0] a_r;
      logic [RW-SEG-1:0] b_r;

      // Upper operand slices travel unchanged to the stage that resolves them.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          a_r <= {(RW-SEG){1'b0}};
          b_r <= {(RW-SEG){1'b0}};
        end else if (en_s && in_vld_s) begin
          a_r <= in_a_s[RW-1:SEG];
          b_r <= in_b_s[RW-1:SEG];
        end
      end
    end else begin : g_last
      logic ovf_r;

      // Signed overflow: like-signed operands producing an opposite-signed sum.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          ovf_r <= 1'b0;
        end else if (en_s && in_vld_s) begin
          ovf_r <= (in_a_s[RW-1] == in_b_s[RW-1]) && (res_s[SEG-1] != in_a_s[RW-1]);
        end
      end
    end
  end

  assign en_s          = ~g_stage[NSEG-1].vld_r | bus.out_ready;
  assign bus.in_ready  = en_s;
  assign bus.out_valid = g_stage[NSEG-1].vld_r;
  assign bus.sum       = g_stage[NSEG-1].s_r;
  assign bus.cout      = g_stage[NSEG-1].c_r;
  assign bus.ovf       = g_stage[NSEG-1].g_last.ovf_r;
endmodule

// File: tb/tb_pe_add_pipe.sv
// Self-checking bench for pe_add_pipe: directed corner cases plus a randomized
// scoreboard run against an arithmetic reference model.
module tb_pe_add_pipe;
  localparam int W = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pe_add_pipe_if #(.W(W)) bus ();
  pe_add_pipe #(.W(W), .SEG(16)) u_dut (.clk(clk), .rst(rst), .bus(bus));

  pe_add_pipe_if #(.W(24)) bus24 ();
  pe_add_pipe #(.W(24), .SEG(8)) u_dut24 (.clk(clk), .rst(rst), .bus(bus24));

  int n_assert = 0;
  int n_fail   = 0;
  int n_out    = 0;
  logic [65:0] exp_q [$];

  task automatic chk(input string tag, input logic [66:0] obs, input logic [66:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: {ovf, cout, sum} from plain unsigned and signed arithmetic.
  function automatic logic [65:0] ref_add(input logic [63:0] x, input logic [63:0] y,
                                          input logic ci, input logic o);
    logic [63:0]        ye;
    logic               ce;
    logic [64:0]        u;
    logic signed [65:0] s;
    ye = o ? ~y : y;
    ce = o ? ~ci : ci;
    u  = {1'b0, x} + {1'b0, ye} + {64'd0, ce};
    s  = $signed({{2{x[63]}}, x}) + $signed({{2{ye[63]}}, ye}) + $signed({65'd0, ce});
    return {s[64] != s[63], u[64], u[63:0]};
  endfunction

  // One clock of scoreboard traffic; checks handshake, ordering and stall stability.
  task automatic cycle(input logic iv, input logic [63:0] ia, input logic [63:0] ib,
                       input logic icin, input logic iop, input logic ior, output logic acc);
    logic        hold;
    logic [65:0] held;
    logic [65:0] exp_e;
    bus.in_valid = iv; bus.a = ia; bus.b = ib; bus.cin = icin; bus.op = iop;
    bus.out_ready = ior;
    #1;
    chk("in_ready_rule", {66'd0, bus.in_ready}, {66'd0, !(bus.out_valid && !ior)});
    acc = iv && bus.in_ready;
    if (acc) exp_q.push_back(ref_add(ia, ib, icin, iop));
    hold = bus.out_valid && !ior;
    held = {bus.ovf, bus.cout, bus.sum};
    if (bus.out_valid && ior) begin
      n_out++;
      exp_e = (exp_q.size() > 0) ? exp_q.pop_front() : {66{1'bx}};
      chk("result_order", {1'b0, bus.ovf, bus.cout, bus.sum}, {1'b0, exp_e});
    end
    @(posedge clk); #1;
    if (hold) chk("stall_hold", {bus.out_valid, bus.ovf, bus.cout, bus.sum}, {1'b1, held});
  endtask

  // Single beat into an empty pipe; measures edges from acceptance to out_valid.
  task automatic lat_beat(input string tag, input logic [63:0] ia, input logic [63:0] ib,
                          input logic icin, input logic iop, input logic [63:0] es,
                          input logic ec, input logic eo);
    int n;
    bus.a = ia; bus.b = ib; bus.cin = icin; bus.op = iop;
    bus.out_ready = 1'b1; bus.in_valid = 1'b1;
    #1;
    chk({tag, "_in_ready"}, {66'd0, bus.in_ready}, {66'd0, 1'b1});
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    n = 1;
    while (!bus.out_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "_latency"}, 67'(n), 67'd4);
    chk({tag, "_result"}, {1'b0, bus.ovf, bus.cout, bus.sum}, {1'b0, eo, ec, es});
    @(posedge clk); #1;
  endtask

  initial begin
    logic        acc;
    logic [7:0]  pat;
    int          beat;
    int          base;
    int          n;

    bus.in_valid = 1'b0; bus.a = 64'd0; bus.b = 64'd0; bus.cin = 1'b0; bus.op = 1'b0;
    bus.out_ready = 1'b1;
    bus24.in_valid = 1'b0; bus24.a = 24'd0; bus24.b = 24'd0; bus24.cin = 1'b0;
    bus24.op = 1'b0; bus24.out_ready = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", {bus.out_valid, bus.ovf, bus.cout, bus.sum}, 67'd0);
    rst = 1'b0;
    #1;
    chk("reset_in_ready", {66'd0, bus.in_ready}, {66'd0, 1'b1});

    lat_beat("carry_wrap", 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 64'd0, 1'b1, 1'b0);
    lat_beat("sub_borrow", 64'd5, 64'd7, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0);
    lat_beat("sub_bin", 64'd7, 64'd5, 1'b1, 1'b1, 64'd1, 1'b1, 1'b0);
    lat_beat("add_ovf", 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0,
             64'h8000_0000_0000_0000, 1'b0, 1'b1);
    lat_beat("sub_ovf", 64'h8000_0000_0000_0000, 64'd1, 1'b0, 1'b1,
             64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1);

    // Back-to-back beats under a fixed out_ready pattern 1,0,0,1,0,1,1,0.
    pat  = 8'b0110_1001;
    beat = 0;
    base = n_out;
    for (int c = 0; c < 200 && (beat < 8 || exp_q.size() > 0); c++) begin
      cycle(beat < 8, 64'(beat), 64'h1_0000_FFFF, 1'b0, 1'b0, pat[c % 8], acc);
      if (acc) beat++;
    end
    chk("b2b_count", 67'(n_out - base), 67'd8);

    // Random traffic with random backpressure, then drain.
    for (int c = 0; c < 300; c++) begin
      cycle(1'($urandom_range(0, 3) != 0), {$urandom, $urandom}, {$urandom, $urandom},
            1'($urandom), 1'($urandom), 1'($urandom_range(0, 2) != 0), acc);
    end
    for (int c = 0; c < 50 && exp_q.size() > 0; c++) begin
      cycle(1'b0, 64'd0, 64'd0, 1'b0, 1'b0, 1'b1, acc);
    end
    chk("random_drain", 67'(exp_q.size()), 67'd0);

    // Fill and stall, then reset asynchronously between clock edges.
    bus.out_ready = 1'b0; bus.in_valid = 1'b1; bus.op = 1'b0; bus.cin = 1'b0;
    bus.a = 64'd100; bus.b = 64'd23;
    repeat (5) @(posedge clk);
    #1;
    chk("stall_full", {65'd0, bus.out_valid, bus.in_ready}, {65'd0, 1'b1, 1'b0});
    #2 rst = 1'b1;
    #1;
    chk("async_reset", {bus.out_valid, bus.ovf, bus.cout, bus.sum}, 67'd0);
    rst = 1'b0;
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    n = 0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      if (bus.out_valid) n++;
    end
    chk("no_stale", 67'(n), 67'd0);
    lat_beat("post_reset", 64'd40, 64'd2, 1'b0, 1'b0, 64'd42, 1'b0, 1'b0);

    // Narrow configuration: three 8-bit stages.
    bus24.a = 24'hFF_FFFF; bus24.b = 24'd0; bus24.cin = 1'b1; bus24.op = 1'b0;
    bus24.in_valid = 1'b1;
    @(posedge clk); #1;
    bus24.in_valid = 1'b0;
    n = 1;
    while (!bus24.out_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("w24_latency", 67'(n), 67'd3);
    chk("w24_result", {40'd0, bus24.ovf, bus24.cout, bus24.sum}, {40'd0, 1'b0, 1'b1, 24'd0});

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
